// File: rtl/dot_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dot_pkg
//  Description : Shared types and widths for the dot-product pipeline
//                (tree, loader and accumulate/requantise stages).
//  Revision    : 1.0  initial release
// ============================================================================
package dot_pkg;

  // Default datapath widths
  localparam int IN_WIDTH_DEF    = 16;
  localparam int CHUNK_WIDTH_DEF = 8;
  localparam int ACC_WIDTH_DEF   = IN_WIDTH_DEF + CHUNK_WIDTH_DEF;
  localparam int ACT_WIDTH_DEF   = 4;
  localparam int SCALE_WIDTH_DEF = 8;
  localparam int SHIFT_WIDTH_DEF = 5;

  // Saturation limits of the default signed activation
  localparam int SAT_MIN = -(2 ** (ACT_WIDTH_DEF - 1));
  localparam int SAT_MAX = (2 ** (ACT_WIDTH_DEF - 1)) - 1;

  // Output-group state machine
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACCUM = 3'd1,
    RQ1   = 3'd2,
    RQ2   = 3'd3,
    OUT   = 3'd4
  } dot_state_e;

endpackage : dot_pkg
`default_nettype wire

// File: rtl/requant_core.sv
`default_nettype none
// ============================================================================
//  Module      : requant_core
//  Description : Two registered requantisation stages. Stage 1 adds the bias
//                and multiplies by the unsigned scale; stage 2 applies a
//                round-half-up arithmetic right shift, optional ReLU and
//                saturation to the signed activation width.
//  Revision    : 1.0  initial release
// ============================================================================
module requant_core
  import dot_pkg::*;
#(
  parameter int ACC_WIDTH   = ACC_WIDTH_DEF,
  parameter int ACT_WIDTH   = ACT_WIDTH_DEF,
  parameter int SCALE_WIDTH = SCALE_WIDTH_DEF,
  parameter int SHIFT_WIDTH = SHIFT_WIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rq1_en_i,
  input  logic                          rq2_en_i,
  input  logic signed [ACC_WIDTH-1:0]   acc_i,
  input  logic signed [ACC_WIDTH-1:0]   bias_i,
  input  logic        [SCALE_WIDTH-1:0] scale_i,
  input  logic        [SHIFT_WIDTH-1:0] shift_i,
  input  logic                          relu_i,
  output logic signed [ACT_WIDTH-1:0]   data_o
);

  // Product holds (acc+bias) * {0,scale} without loss; one extra bit on top
  // keeps the rounding addend from overflowing at large shifts.
  localparam int PROD_WIDTH = ACC_WIDTH + SCALE_WIDTH + 2;
  localparam int RND_WIDTH  = PROD_WIDTH + 1;

  localparam logic signed [RND_WIDTH-1:0] SAT_LO = RND_WIDTH'(-(2 ** (ACT_WIDTH - 1)));
  localparam logic signed [RND_WIDTH-1:0] SAT_HI = RND_WIDTH'((2 ** (ACT_WIDTH - 1)) - 1);

  logic signed [ACC_WIDTH:0]      sum;
  logic signed [PROD_WIDTH-1:0]   sum_ext;
  logic signed [PROD_WIDTH-1:0]   scale_ext;
  logic signed [PROD_WIDTH-1:0]   prod_d;
  logic signed [PROD_WIDTH-1:0]   prod_q;
  logic signed [RND_WIDTH-1:0]    half;
  logic signed [RND_WIDTH-1:0]    shifted;
  logic signed [RND_WIDTH-1:0]    clamped;
  logic signed [ACT_WIDTH-1:0]    data_d;
  logic signed [ACT_WIDTH-1:0]    data_q;

  // Stage 1 arithmetic: bias add then signed multiply by the zero-extended scale
  always_comb begin
    sum       = {acc_i[ACC_WIDTH-1], acc_i} + {bias_i[ACC_WIDTH-1], bias_i};
    sum_ext   = PROD_WIDTH'(sum);
    scale_ext = $signed(PROD_WIDTH'(scale_i));
    prod_d    = sum_ext * scale_ext;
  end

  // Stage 2 arithmetic: round-half-up shift, ReLU, saturate
  always_comb begin
    half = '0;
    if (shift_i != '0) begin
      half = RND_WIDTH'(1) << (shift_i - SHIFT_WIDTH'(1));
    end
    shifted = (RND_WIDTH'(prod_q) + half) >>> shift_i;
    clamped = shifted;
    if (relu_i && shifted[RND_WIDTH-1]) begin
      clamped = '0;
    end
    if (clamped < SAT_LO) begin
      data_d = ACT_WIDTH'(SAT_LO);
    end else if (clamped > SAT_HI) begin
      data_d = ACT_WIDTH'(SAT_HI);
    end else begin
      data_d = ACT_WIDTH'(clamped);
    end
  end

  // Pipeline registers, each loaded only in its own FSM state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q <= '0;
      data_q <= '0;
    end else begin
      if (rq1_en_i) prod_q <= prod_d;
      if (rq2_en_i) data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule : requant_core
`default_nettype wire

// File: rtl/dot_accum_requant.sv
`default_nettype none
// ============================================================================
//  Module      : dot_accum_requant
//  Description : Accumulates a configurable number of partial dot products,
//                requantises the sum to a signed activation and presents it
//                on a valid/ready output. Flags chunks that arrive while the
//                block cannot accept them.
//  Revision    : 1.0  initial release
// ============================================================================
module dot_accum_requant
  import dot_pkg::*;
#(
  parameter int IN_WIDTH    = IN_WIDTH_DEF,
  parameter int ACC_WIDTH   = ACC_WIDTH_DEF,
  parameter int ACT_WIDTH   = ACT_WIDTH_DEF,
  parameter int SCALE_WIDTH = SCALE_WIDTH_DEF,
  parameter int SHIFT_WIDTH = SHIFT_WIDTH_DEF,
  parameter int CHUNK_WIDTH = CHUNK_WIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic signed [IN_WIDTH-1:0]    in_result,
  input  logic        [CHUNK_WIDTH-1:0] cfg_chunks,
  input  logic signed [ACC_WIDTH-1:0]   cfg_bias,
  input  logic        [SCALE_WIDTH-1:0] cfg_scale,
  input  logic        [SHIFT_WIDTH-1:0] cfg_shift,
  input  logic                          cfg_relu,
  input  logic                          err_clr,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [ACT_WIDTH-1:0]   out_data,
  output logic                          busy,
  output logic                          err_overrun
);

  dot_state_e                   state_q, state_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [CHUNK_WIDTH-1:0]       count_q, count_d;
  logic [CHUNK_WIDTH-1:0]       chunks_q, chunks_d;
  logic signed [ACC_WIDTH-1:0]  bias_q, bias_d;
  logic [SCALE_WIDTH-1:0]       scale_q, scale_d;
  logic [SHIFT_WIDTH-1:0]       shift_q, shift_d;
  logic                         relu_q, relu_d;
  logic                         out_valid_q, out_valid_d;
  logic                         err_q, err_d;

  logic                         xfer;
  logic                         start;
  logic [CHUNK_WIDTH-1:0]       chunks_in_eff;
  logic [CHUNK_WIDTH-1:0]       count_inc;
  logic signed [ACC_WIDTH-1:0]  in_ext;

  assign xfer          = out_valid_q & out_ready;
  // A new group opens from IDLE, or from OUT on the very edge the result leaves
  assign start         = in_valid & ((state_q == IDLE) | ((state_q == OUT) & xfer));
  assign chunks_in_eff = (cfg_chunks == '0) ? CHUNK_WIDTH'(1) : cfg_chunks;
  assign count_inc     = count_q + CHUNK_WIDTH'(1);
  assign in_ext        = ACC_WIDTH'(in_result);

  // Next-state, accumulator, shadow-config and error-flag logic
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    chunks_d    = chunks_q;
    bias_d      = bias_q;
    scale_d     = scale_q;
    shift_d     = shift_q;
    relu_d      = relu_q;
    out_valid_d = out_valid_q;
    // Clear first so that a same-cycle overrun below wins over err_clr
    err_d       = err_q & ~err_clr;

    unique case (state_q)
      IDLE: begin
        // Group opening is handled by the start path below
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d   = acc_q + in_ext;
          count_d = count_inc;
          if (count_inc == chunks_q) state_d = RQ1;
        end
      end
      RQ1: begin
        state_d = RQ2;
        if (in_valid) err_d = 1'b1;
      end
      RQ2: begin
        state_d     = OUT;
        out_valid_d = 1'b1;
        if (in_valid) err_d = 1'b1;
      end
      OUT: begin
        if (xfer) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else if (in_valid) begin
          err_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    if (start) begin
      chunks_d = chunks_in_eff;
      bias_d   = cfg_bias;
      scale_d  = cfg_scale;
      shift_d  = cfg_shift;
      relu_d   = cfg_relu;
      acc_d    = in_ext;
      count_d  = CHUNK_WIDTH'(1);
      state_d  = (chunks_in_eff == CHUNK_WIDTH'(1)) ? RQ1 : ACCUM;
    end
  end

  // State, accumulator and shadow registers; reset abandons any open group
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      chunks_q    <= CHUNK_WIDTH'(1);
      bias_q      <= '0;
      scale_q     <= '0;
      shift_q     <= '0;
      relu_q      <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      chunks_q    <= chunks_d;
      bias_q      <= bias_d;
      scale_q     <= scale_d;
      shift_q     <= shift_d;
      relu_q      <= relu_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  requant_core #(
    .ACC_WIDTH   (ACC_WIDTH),
    .ACT_WIDTH   (ACT_WIDTH),
    .SCALE_WIDTH (SCALE_WIDTH),
    .SHIFT_WIDTH (SHIFT_WIDTH)
  ) u_requant_core (
    .clk      (clk),
    .rst      (rst),
    .rq1_en_i (state_q == RQ1),
    .rq2_en_i (state_q == RQ2),
    .acc_i    (acc_q),
    .bias_i   (bias_q),
    .scale_i  (scale_q),
    .shift_i  (shift_q),
    .relu_i   (relu_q),
    .data_o   (out_data)
  );

  assign out_valid   = out_valid_q;
  assign busy        = (state_q != IDLE);
  assign err_overrun = err_q;

endmodule : dot_accum_requant
`default_nettype wire

// File: tb/tb_dot_accum_requant.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dot_accum_requant
//  Description : Directed self-checking bench for dot_accum_requant.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dot_accum_requant;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic signed [15:0] in_result;
  logic [7:0]        cfg_chunks;
  logic signed [23:0] cfg_bias;
  logic [7:0]        cfg_scale;
  logic [4:0]        cfg_shift;
  logic              cfg_relu;
  logic              err_clr;
  logic              out_valid;
  logic              out_ready;
  logic signed [3:0] out_data;
  logic              busy;
  logic              err_overrun;

  int checks = 0;
  int errors = 0;

  dot_accum_requant dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_result   (in_result),
    .cfg_chunks  (cfg_chunks),
    .cfg_bias    (cfg_bias),
    .cfg_scale   (cfg_scale),
    .cfg_shift   (cfg_shift),
    .cfg_relu    (cfg_relu),
    .err_clr     (err_clr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .busy        (busy),
    .err_overrun (err_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute guard so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int chunks, input int bias, input int scale,
                         input int shift, input bit relu);
    cfg_chunks = 8'(chunks);
    cfg_bias   = 24'(bias);
    cfg_scale  = 8'(scale);
    cfg_shift  = 5'(shift);
    cfg_relu   = relu;
  endtask

  // One-cycle in_valid pulse; returns just after the sampling edge
  task automatic pulse(input int value);
    in_valid  = 1'b1;
    in_result = 16'(value);
    step();
    in_valid  = 1'b0;
  endtask

  task automatic take(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_valid_after_xfer"}, int'(out_valid), 0);
  endtask

  // Single-chunk group: valid must rise exactly two edges after the sample
  task automatic run_one(input string tag, input int value, input int exp);
    pulse(value);
    step();
    chk({tag, "_valid_early"}, int'(out_valid), 0);
    step();
    chk({tag, "_valid"}, int'(out_valid), 1);
    chk({tag, "_data"}, int'(out_data), exp);
    take(tag);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_result = '0; err_clr = 1'b0; out_ready = 1'b0;
    set_cfg(1, 0, 1, 0, 0);
    step(); step();
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err_overrun), 0);
    rst = 1'b0;
    step();

    // 1: (100+8)>>>4 = 6
    set_cfg(1, 0, 1, 4, 0);
    run_one("t1", 100, 6);

    // 2: (-100+8)>>>4 = -6; ReLU -> 0; shift 0 saturates to 7 / -8
    run_one("t2_neg", -100, -6);
    set_cfg(1, 0, 1, 4, 1);
    run_one("t2_relu", -100, 0);
    set_cfg(1, 0, 1, 0, 0);
    run_one("t2_satp", 1000, 7);
    run_one("t2_satn", -1000, -8);

    // 3: acc=25, (25+3)*2=56, (56+4)>>>3 = 7; mid-group cfg change ignored
    set_cfg(3, 3, 2, 3, 0);
    pulse(10);
    set_cfg(1, 100, 9, 0, 1);
    step(); step();
    chk("t3_busy_gap", int'(busy), 1);
    chk("t3_valid_gap1", int'(out_valid), 0);
    pulse(20);
    step(); step();
    chk("t3_valid_gap2", int'(out_valid), 0);
    pulse(-5);
    step();
    chk("t3_valid_early", int'(out_valid), 0);
    step();
    chk("t3_valid", int'(out_valid), 1);
    chk("t3_data", int'(out_data), 7);
    take("t3");
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_single_valid", int'(out_valid), 0);
    end

    // 4: stall with ready low; a chunk during OUT is dropped and flagged
    set_cfg(1, 0, 1, 0, 0);
    pulse(5);
    step(); step();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        in_valid = 1'b1; in_result = 16'sd3;
      end
      step();
      in_valid = 1'b0;
      chk("t4_stall_valid", int'(out_valid), 1);
      chk("t4_stall_data", int'(out_data), 5);
      chk("t4_stall_busy", int'(busy), 1);
    end
    chk("t4_err_set", int'(err_overrun), 1);
    in_valid = 1'b1; err_clr = 1'b1; in_result = 16'sd1;
    step();
    in_valid = 1'b0; err_clr = 1'b0;
    chk("t4_set_wins", int'(err_overrun), 1);
    take("t4");
    run_one("t4_next", 2, 2);
    chk("t4_err_sticky", int'(err_overrun), 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("t4_err_clr", int'(err_overrun), 0);

    // 5: chunk arriving on the transfer edge opens the next group
    pulse(4);
    step(); step();
    chk("t5_first", int'(out_data), 4);
    out_ready = 1'b1; in_valid = 1'b1; in_result = 16'sd6;
    step();
    out_ready = 1'b0; in_valid = 1'b0;
    chk("t5_valid_drop", int'(out_valid), 0);
    chk("t5_busy", int'(busy), 1);
    step();
    chk("t5_valid_early", int'(out_valid), 0);
    step();
    chk("t5_valid", int'(out_valid), 1);
    chk("t5_data", int'(out_data), 6);
    chk("t5_err", int'(err_overrun), 0);
    take("t5");

    // 6: async reset mid-accumulation, then a fresh 3-chunk group
    set_cfg(3, 0, 1, 0, 0);
    pulse(2);
    step();
    pulse(3);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_data", int'(out_data), 0);
    chk("t6_rst_valid", int'(out_valid), 0);
    chk("t6_rst_err", int'(err_overrun), 0);
    step();
    rst = 1'b0;
    step();
    pulse(1);
    pulse(1);
    step(); step();
    chk("t6_no_early_out", int'(out_valid), 0);
    pulse(1);
    step();
    step();
    chk("t6_valid", int'(out_valid), 1);
    chk("t6_data", int'(out_data), 3);
    take("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_dot_accum_requant
`default_nettype wire
